dortlu_mux_hakem: RTL and testbench

- Round-robin arbiter that shares one 4-to-1 mux datapath (the dortlu_mux select pair S1/S0 plus the active-low enable E of the gated selector stage) between four requesters.
- Grants one requester at a time and holds the grant for a bounded burst.
- Inserts a dead cycle (E high, no grant) on every ownership change so the datapath never switches source while enabled.
- Sits between the requesting blocks and the mux/selector datapath. It drives select and enable directly.

---
 rtl/dortlu_mux_hakem.sv | 129 ++++++++++++
 tb/tb_dortlu_mux_hakem.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dortlu_mux_hakem.sv
// rtl/dortlu_mux_hakem.sv - round-robin arbiter driving the shared 4-to-1 mux select and enable
// Bursts are bounded by MAX_BURST; every ownership change passes through a one-cycle dead gap.
module dortlu_mux_hakem #(
  parameter int MAX_BURST = 4,
  parameter int CW        = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] SEL,
  output logic       E,
  output logic       BUSY
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          e_q, e_d;
  logic          busy_q, busy_d;

  logic [1:0]    pick_idx;
  logic          own_req;
  logic          others_req;
  logic          at_max;

  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    logic [1:0] res;
    res   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    e_d        = e_q;
    busy_d     = busy_q;
    pick_idx   = pick(REQ, ptr_q);
    own_req    = REQ[owner_q];
    others_req = |(REQ & ~(4'b0001 << owner_q));
    at_max     = (cnt_q == CW'(MAX_BURST));

    case (state_q)
      IDLE, GAP: begin
        if (|REQ) begin
          state_d = GRANT;
          owner_d = pick_idx;
          cnt_d   = CW'(1);
          gnt_d   = 4'b0001 << pick_idx;
          sel_d   = pick_idx;
          e_d     = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          e_d     = 1'b1;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        // Release and forced rotation share the same exit: drop the grant, move the pointer past the owner.
        if (!own_req || (at_max && others_req)) begin
          state_d = GAP;
          gnt_d   = 4'b0000;
          e_d     = 1'b1;
          busy_d  = 1'b1;
          ptr_d   = owner_q + 2'd1;
        end else if (at_max) begin
          cnt_d = CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        e_d     = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      e_q     <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT  = gnt_q;
  assign SEL  = sel_q;
  assign E    = e_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_dortlu_mux_hakem.sv
// tb/tb_dortlu_mux_hakem.sv - directed scenario bench for dortlu_mux_hakem
module tb_dortlu_mux_hakem;

  logic       CLK;
  logic       RST_N;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [1:0] SEL;
  logic       E;
  logic       BUSY;

  int n_vec = 0;
  int n_err = 0;

  dortlu_mux_hakem #(.MAX_BURST(4), .CW(3)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .REQ  (REQ),
    .GNT  (GNT),
    .SEL  (SEL),
    .E    (E),
    .BUSY (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] req);
    RST_N = 1'b0;
    REQ   = req;
    tick();
    RST_N = 1'b1;
  endtask

  // Invariants sampled on every falling edge while out of reset.
  logic [1:0] prev_sel;
  logic       prev_e;
  logic       prev_valid = 1'b0;
  always @(negedge CLK) begin
    if (RST_N) begin
      n_vec++;
      if (!$onehot0(GNT)) begin
        n_err++;
        $display("FAIL inv_onehot: GNT=%b not zero/one-hot", GNT);
      end
      n_vec++;
      if (E !== (GNT == 4'b0000)) begin
        n_err++;
        $display("FAIL inv_enable: E=%b GNT=%b, required E=%b", E, GNT, (GNT == 4'b0000));
      end
      if (prev_valid && !prev_e && !E) begin
        n_vec++;
        if (SEL !== prev_sel) begin
          n_err++;
          $display("FAIL inv_sel_stable: SEL %b -> %b while E stayed 0", prev_sel, SEL);
        end
      end
      prev_sel   = SEL;
      prev_e     = E;
      prev_valid = 1'b1;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] s,
                            input logic e, input logic b);
    n_vec++;
    if (GNT !== g || SEL !== s || E !== e || BUSY !== b) begin
      n_err++;
      $display("FAIL %s: GNT=%b SEL=%b E=%b BUSY=%b, required GNT=%b SEL=%b E=%b BUSY=%b",
               name, GNT, SEL, E, BUSY, g, s, e, b);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    REQ   = 4'b1111;
    repeat (3) tick();
    n_vec++;
    if (GNT !== 4'b0000 || SEL !== 2'b00 || E !== 1'b1 || BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: GNT=%b SEL=%b E=%b BUSY=%b, required 0000 00 1 0", GNT, SEL, E, BUSY);
    end
    RST_N = 1'b1;
    tick();
    n_vec++;
    if (GNT !== 4'b0001 || E !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_grant: GNT=%b E=%b, required 0001 0", GNT, E);
    end
    #2;
    RST_N = 1'b0;
    #1;
    n_vec++;
    if (GNT !== 4'b0000 || E !== 1'b1 || BUSY !== 1'b0 || SEL !== 2'b00) begin
      n_err++;
      $display("FAIL reset_async: GNT=%b E=%b BUSY=%b SEL=%b, required 0000 1 0 00", GNT, E, BUSY, SEL);
    end
  endtask

  task automatic test_single();
    do_reset(4'b0000);
    tick();
    expect_out("single_idle", 4'b0000, 2'b00, 1'b1, 1'b0);
    REQ = 4'b0100;
    tick();
    expect_out("single_first", 4'b0100, 2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (GNT !== 4'b0100 || E !== 1'b0) begin
        n_err++;
        $display("FAIL single_hold[%0d]: GNT=%b E=%b, required 0100 0", i, GNT, E);
      end
    end
    REQ = 4'b0000;
    tick();
    expect_out("single_gap", 4'b0000, 2'b10, 1'b1, 1'b1);
    tick();
    expect_out("single_idle_after", 4'b0000, 2'b10, 1'b1, 1'b0);
  endtask

  task automatic test_full_contention();
    logic [3:0] eg;
    logic [1:0] es;
    do_reset(4'b1111);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (r == 4 && c > 0) break;
        tick();
        es = 2'(r % 4);
        eg = (c < 4) ? (4'b0001 << es) : 4'b0000;
        expect_out($sformatf("contention_r%0d_c%0d", r, c), eg, es, (c == 4), 1'b1);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset(4'b0000);
    REQ = 4'b0011;
    tick();
    expect_out("early_own0_c1", 4'b0001, 2'b00, 1'b0, 1'b1);
    tick();
    expect_out("early_own0_c2", 4'b0001, 2'b00, 1'b0, 1'b1);
    REQ = 4'b0010;
    tick();
    expect_out("early_gap", 4'b0000, 2'b00, 1'b1, 1'b1);
    REQ = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out($sformatf("early_own1_c%0d", c + 1), 4'b0010, 2'b01, 1'b0, 1'b1);
    end
    tick();
    expect_out("early_rotate_gap", 4'b0000, 2'b01, 1'b1, 1'b1);
    tick();
    expect_out("early_back_to_0", 4'b0001, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_pointer_wrap();
    do_reset(4'b0000);
    REQ = 4'b1000;
    tick();
    expect_out("wrap_own3", 4'b1000, 2'b11, 1'b0, 1'b1);
    REQ = 4'b1001;
    repeat (3) tick();
    expect_out("wrap_own3_c4", 4'b1000, 2'b11, 1'b0, 1'b1);
    tick();
    expect_out("wrap_gap", 4'b0000, 2'b11, 1'b1, 1'b1);
    tick();
    expect_out("wrap_to_0", 4'b0001, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_sole_regrant();
    do_reset(4'b0000);
    REQ = 4'b0001;
    tick();
    expect_out("regrant_first", 4'b0001, 2'b00, 1'b0, 1'b1);
    REQ = 4'b0000;
    tick();
    expect_out("regrant_gap", 4'b0000, 2'b00, 1'b1, 1'b1);
    REQ = 4'b0001;
    tick();
    expect_out("regrant_again", 4'b0001, 2'b00, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    REQ   = 4'b0000;
    test_reset();
    test_single();
    test_full_contention();
    test_early_release();
    test_pointer_wrap();
    test_sole_regrant();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
